// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control sequencer for the single-issue datapath. It owns the
//   program counter and steps each instruction through FETCH, EXEC and, for
//   loads/stores, MEM wait states. It gates the decoder's register-write and
//   memory-write strobes so each fires exactly once per instruction, runs the
//   Start/Ack handshake with the test harness, and halts on the decoder's Done.
//
// Ports:
//   Clk        - system clock, all state changes on the rising edge
//   Reset      - synchronous, active-low reset
//   Start      - begin execution at StartAddr (accepted in IDLE and HALT)
//   StartAddr  - program entry point
//   Branch     - decoder: branch instruction
//   BrTaken    - ALU condition flag, used only for a branch in EXEC
//   BrOffset   - signed two's-complement branch displacement
//   RegWrite   - decoder: instruction writes the register file
//   MemtoReg   - decoder: load
//   MemWrite   - decoder: store
//   Done       - decoder: halt instruction
//   ProgCtr    - registered instruction memory address
//   InstrLatch - capture the instruction register this cycle
//   RegWrEn    - gated register-file write enable
//   MemWrEn    - gated data-memory write strobe
//   MemEn      - data-memory access in progress
//   Ack        - registered program-halted flag
//   Busy       - sequencer is in FETCH, EXEC or MEM
//   CycleCnt   - saturating count of busy cycles since the last accepted Start
// ----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int PC_W    = 10,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Branch,
    input  logic             BrTaken,
    input  logic [PC_W-1:0]  BrOffset,
    input  logic             RegWrite,
    input  logic             MemtoReg,
    input  logic             MemWrite,
    input  logic             Done,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             InstrLatch,
    output logic             RegWrEn,
    output logic             MemWrEn,
    output logic             MemEn,
    output logic             Ack,
    output logic             Busy,
    output logic [CNT_W-1:0] CycleCnt
);

    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc_next;
    logic              ack_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              cnt_clr;
    logic              busy_raw;
    logic              latch_raw;
    logic              regwr_raw;
    logic              memwr_raw;
    logic              memen_raw;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            ProgCtr  <= '0;
            Ack      <= 1'b0;
            CycleCnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            ProgCtr  <= pc_next;
            Ack      <= ack_next;
            wait_cnt <= wait_next;
            if (cnt_clr) begin
                CycleCnt <= '0;
            end else if (busy_raw && (CycleCnt != {CNT_W{1'b1}})) begin
                CycleCnt <= CycleCnt + CNT_W'(1);
            end
        end
    end

    assign busy_raw = (state == FETCH) || (state == EXEC) || (state == MEM);

    always_comb begin
        state_next = state;
        pc_next    = ProgCtr;
        ack_next   = Ack;
        wait_next  = wait_cnt;
        cnt_clr    = 1'b0;
        latch_raw  = 1'b0;
        regwr_raw  = 1'b0;
        memwr_raw  = 1'b0;
        memen_raw  = 1'b0;

        case (state)
            IDLE: begin
                if (Start) begin
                    pc_next    = StartAddr;
                    cnt_clr    = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                latch_raw  = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                // Done outranks a memory op, which outranks branch/ALU.
                if (Done) begin
                    ack_next   = 1'b1;
                    state_next = HALT;
                end else if (MemtoReg || MemWrite) begin
                    memen_raw  = 1'b1;
                    wait_next  = WAIT_W'(MEM_LAT - 1);
                    state_next = MEM;
                end else begin
                    regwr_raw = RegWrite;
                    // Same-width add gives modulo 2^PC_W, so a negative
                    // offset wraps backwards without explicit sign extension.
                    if (Branch && BrTaken) begin
                        pc_next = ProgCtr + BrOffset;
                    end else begin
                        pc_next = ProgCtr + PC_W'(1);
                    end
                    state_next = FETCH;
                end
            end
            MEM: begin
                memen_raw = 1'b1;
                if (wait_cnt != '0) begin
                    wait_next = wait_cnt - WAIT_W'(1);
                end else begin
                    // Final access cycle: the only cycle that strobes.
                    regwr_raw  = MemtoReg;
                    memwr_raw  = MemWrite;
                    pc_next    = ProgCtr + PC_W'(1);
                    state_next = FETCH;
                end
            end
            HALT: begin
                if (Start) begin
                    pc_next    = StartAddr;
                    cnt_clr    = 1'b1;
                    ack_next   = 1'b0;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Combinational outputs are suppressed while reset is held so an aborted
    // instruction never issues a strobe.
    assign InstrLatch = Reset & latch_raw;
    assign RegWrEn    = Reset & regwr_raw;
    assign MemWrEn    = Reset & memwr_raw;
    assign MemEn      = Reset & memen_raw;
    assign Busy       = Reset & busy_raw;

endmodule
